// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto one shared combinational ALU and returns each result over a valid/ready response port.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); otherwise arbitration is round-robin.
module alu_share_ctrl #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [5:0]  req0_op,
  input  logic [5:0]  req1_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_negative,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_negative,
  output logic        rsp_zero,
  output logic        busy
);

  localparam logic [5:0] OP_ERROR = 6'd38;
  localparam logic [1:0] LAST_CNT = 2'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [5:0]  op_q, op_d;
  logic        id_q, id_d;
  logic [31:0] res_q, res_d;
  logic        neg_q, neg_d, zero_q, zero_d;
  logic        grant_id, any_valid;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic        ptr_q, ptr_d;
`endif

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ERROR;
      id_q    <= 1'b0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // ptr_q names the favoured requester, i.e. the one not granted last time.
  always_comb begin
    any_valid = req0_valid | req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant_id  = ~req0_valid;
`else
    grant_id  = (req0_valid && req1_valid) ? ptr_q : ~req0_valid;
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    id_d       = id_q;
    res_d      = res_q;
    neg_d      = neg_q;
    zero_d     = zero_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          a_d        = grant_id ? req1_a : req0_a;
          b_d        = grant_id ? req1_b : req0_b;
          op_d       = grant_id ? req1_op : req0_op;
          id_d       = grant_id;
          cnt_d      = '0;
          state_d    = EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
          ptr_d      = ~grant_id;
`endif
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_CNT) begin
          res_d   = alu_result;
          neg_d   = alu_negative;
          zero_d  = alu_zero;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The ALU sees a neutral ERROR operation whenever no operation is executing.
  always_comb begin
    alu_a        = (state_q == EXEC) ? a_q : 32'd0;
    alu_b        = (state_q == EXEC) ? b_q : 32'd0;
    alu_op       = (state_q == EXEC) ? op_q : OP_ERROR;
    rsp_valid    = (state_q == RESP);
    busy         = (state_q != IDLE);
    rsp_id       = id_q;
    rsp_result   = res_q;
    rsp_negative = neg_q;
    rsp_zero     = zero_q;
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: transaction-level reference model, directed scenarios and random traffic.
// Honours ALU_ARB_FIXED_PRIO_EN the same way the design does.
module tb_alu_share_ctrl;

  localparam int EXEC = 3;

  logic        clk = 1'b0;
  logic        nRst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [5:0]  alu_op;
  logic        alu_negative, alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_negative, rsp_zero, busy;
  logic [31:0] rsp_result;

  int checks = 0;
  int failures = 0;

  // Transaction-level model: busy from handshake until response acceptance; age counts cycles since handshake.
  bit          mBusy;
  int          mAge;
  bit          mFav;
  logic [31:0] mA, mB;
  logic [5:0]  mOp;
  bit          mId;
  logic [33:0] mRsp;

  logic        obsR0, obsR1, obsRv, obsBusy, obsId, obsNeg, obsZero;
  logic [31:0] obsRes;
  logic [5:0]  obsAluOp;
  int          grantLog[$];

  alu_share_ctrl #(.EXEC_CYCLES(EXEC)) dut (
    .clk(clk), .nRst(nRst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_negative(rsp_negative), .rsp_zero(rsp_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared ALU: returns {negative, zero, result}; unsupported opcodes give all zeros.
  function automatic logic [33:0] aluFn(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
    logic [31:0] r;
    logic known;
    known = 1'b1;
    r = 32'd0;
    case (op)
      6'd28: r = a + b;
      6'd29: r = a - b;
      6'd31: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd37: r = a & b;
      default: known = 1'b0;
    endcase
    return {known & r[31], known & (r == 32'd0), r};
  endfunction

  always_comb {alu_negative, alu_zero, alu_result} = aluFn(alu_a, alu_b, alu_op);

  function automatic bit pick();
`ifdef ALU_ARB_FIXED_PRIO_EN
    return req0_valid ? 1'b0 : 1'b1;
`else
    if (req0_valid && req1_valid) return mFav;
    return req0_valid ? 1'b0 : 1'b1;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [31:0] eA, eB;
    logic [5:0]  eOp;
    logic        eR0, eR1, eRv;
    bit          g;
    eA = 32'd0; eB = 32'd0; eOp = 6'd38; eR0 = 1'b0; eR1 = 1'b0;
    eRv = mBusy && (mAge > EXEC);
    if (!mBusy) begin
      if (req0_valid || req1_valid) begin
        g = pick();
        eR0 = !g;
        eR1 = g;
      end
    end else if (mAge <= EXEC) begin
      eA = mA; eB = mB; eOp = mOp;
    end
    obsR0 = req0_ready; obsR1 = req1_ready; obsRv = rsp_valid; obsBusy = busy;
    obsId = rsp_id; obsRes = rsp_result; obsNeg = rsp_negative; obsZero = rsp_zero; obsAluOp = alu_op;
    check("req0_ready", 32'(req0_ready), 32'(eR0));
    check("req1_ready", 32'(req1_ready), 32'(eR1));
    check("busy", 32'(busy), 32'(mBusy));
    check("rsp_valid", 32'(rsp_valid), 32'(eRv));
    check("alu_a", alu_a, eA);
    check("alu_b", alu_b, eB);
    check("alu_op", 32'(alu_op), 32'(eOp));
    if (eRv) begin
      check("rsp_id", 32'(rsp_id), 32'(mId));
      check("rsp_result", rsp_result, mRsp[31:0]);
      check("rsp_negative", 32'(rsp_negative), 32'(mRsp[33]));
      check("rsp_zero", 32'(rsp_zero), 32'(mRsp[32]));
    end
    if (req0_valid && req0_ready) grantLog.push_back(0);
    if (req1_valid && req1_ready) grantLog.push_back(1);
  endtask

  task automatic updateModel();
    bit g;
    if (!nRst) begin
      mBusy = 0; mAge = 0; mFav = 0;
    end else if (!mBusy) begin
      if (req0_valid || req1_valid) begin
        g = pick();
        mA = g ? req1_a : req0_a;
        mB = g ? req1_b : req0_b;
        mOp = g ? req1_op : req0_op;
        mId = g;
        mRsp = aluFn(mA, mB, mOp);
        mFav = !g;
        mBusy = 1; mAge = 1;
      end
    end else if (mAge <= EXEC) begin
      mAge++;
    end else if (rsp_ready) begin
      mBusy = 0;
    end
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the falling edge.
  task automatic applyStimulus();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic doReset();
    nRst = 0; req0_valid = 0; req1_valid = 0;
    applyStimulus();
    nRst = 1;
  endtask

  task automatic directOp(input bit rid, input logic [31:0] a, input logic [31:0] b, input logic [5:0] op, input int hold);
    req0_valid = !rid; req1_valid = rid;
    if (rid) begin req1_a = a; req1_b = b; req1_op = op; end
    else begin req0_a = a; req0_b = b; req0_op = op; end
    rsp_ready = (hold == 0);
    applyStimulus();
    check("lit_grant", 32'(rid ? obsR1 : obsR0), 32'd1);
    req0_valid = 0; req1_valid = 0;
    for (int k = 1; k <= EXEC; k++) begin
      applyStimulus();
      check("lit_rsp_early", 32'(obsRv), 32'd0);
    end
    for (int h = 0; h < hold; h++) begin
      req0_valid = 1; req1_valid = 1;
      applyStimulus();
      check("lit_hold_valid", 32'(obsRv), 32'd1);
      check("lit_hold_ready", 32'({obsR0, obsR1}), 32'd0);
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    applyStimulus();
    check("lit_rsp_valid", 32'(obsRv), 32'd1);
    check("lit_rsp_id", 32'(obsId), 32'(rid));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] opTab [6];
    int exp033 [4];
    opTab[0] = 6'd28; opTab[1] = 6'd29; opTab[2] = 6'd31; opTab[3] = 6'd37; opTab[4] = 6'd38; opTab[5] = 6'd50;
    nRst = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_op = 0; req1_op = 0;
    repeat (2) @(posedge clk);
    #1;
    mBusy = 0; mAge = 0; mFav = 0; mA = 0; mB = 0; mOp = 6'd38; mId = 0; mRsp = '0;

    // Reset state
    applyStimulus();
    check("rst_busy", 32'(obsBusy), 32'd0);
    check("rst_rsp_valid", 32'(obsRv), 32'd0);
    check("rst_alu_op", 32'(obsAluOp), 32'd38);
    check("rst_rsp_result", obsRes, 32'd0);
    check("rst_rsp_id", 32'(obsId), 32'd0);
    nRst = 1;

    directOp(0, 32'd5, 32'd7, 6'd28, 0);
    check("add_result", obsRes, 32'd12);
    check("add_zero", 32'(obsZero), 32'd0);
    check("add_neg", 32'(obsNeg), 32'd0);

    directOp(1, 32'd3, 32'd3, 6'd29, 0);
    check("sub0_result", obsRes, 32'd0);
    check("sub0_zero", 32'(obsZero), 32'd1);
    directOp(1, 32'd2, 32'd5, 6'd29, 0);
    check("subneg_result", obsRes, 32'hFFFFFFFD);
    check("subneg_neg", 32'(obsNeg), 32'd1);

    directOp(0, 32'hF0, 32'h3C, 6'd37, 5);
    check("and_result", obsRes, 32'h30);

    directOp(0, 32'd1, 32'd1, 6'd50, 0);
    check("badop_result", obsRes, 32'd0);
    check("badop_zero", 32'(obsZero), 32'd0);

    // Both requesters continuously valid
    doReset();
    grantLog.delete();
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    req0_a = 32'd10; req0_b = 32'd1; req0_op = 6'd28;
    req1_a = 32'd20; req1_b = 32'd2; req1_op = 6'd29;
    for (int c = 0; c < 80 && grantLog.size() < 4; c++) applyStimulus();
    req0_valid = 0; req1_valid = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp033 = '{0, 0, 0, 0};
`else
    exp033 = '{0, 1, 0, 1};
`endif
    check("grant_count", 32'(grantLog.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < grantLog.size(); i++) check("grant_order", 32'(grantLog[i]), 32'(exp033[i]));
    repeat (EXEC + 2) applyStimulus();

    // Reset during EXEC aborts the operation
    req0_valid = 1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 6'd28;
    applyStimulus();
    req0_valid = 0;
    applyStimulus();
    nRst = 0;
    applyStimulus();
    nRst = 1;
    req1_valid = 1; req1_a = 32'd9; req1_b = 32'd4; req1_op = 6'd29;
    applyStimulus();
    check("abort_busy", 32'(obsBusy), 32'd0);
    check("abort_rsp_valid", 32'(obsRv), 32'd0);
    check("abort_alu_op", 32'(obsAluOp), 32'd38);
    check("abort_grant1", 32'(obsR1), 32'd1);
    req1_valid = 0;
    repeat (EXEC + 1) applyStimulus();
    check("abort_next_result", obsRes, 32'd5);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      nRst = ($urandom_range(0, 99) != 0);
      req0_valid = nRst && ($urandom_range(0, 2) != 0);
      req1_valid = nRst && ($urandom_range(0, 2) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req0_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      req0_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      req1_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      req1_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      req0_op = opTab[$urandom_range(0, 5)];
      req1_op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : opTab[$urandom_range(0, 5)];
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 Parameter: EXEC_CYCLES, 1, cycles operands are held on the ALU before result capture; legal range 1..4.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 nRst  in  1  synchronous active-low reset.
REQ-005 req0_valid, req1_valid  in  1  requester N has an operation pending.
REQ-006 req0_ready, req1_ready  out  1  operation accepted this cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  in  32  operands.
REQ-008 req0_op, req1_op  in  6  ALU opcode: ADD=28, SUB=29, SLT=31, AND=37, ERROR=38.
REQ-009 alu_a, alu_b  out  32; alu_op  out  6  drive the shared ALU instance.
REQ-010 alu_result  in  32; alu_negative, alu_zero  in  1  combinational ALU outputs.
REQ-011 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-012 rsp_id  out  1  requester index; rsp_result  out  32; rsp_negative, rsp_zero  out  1.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, EXEC and RESP.
REQ-015 In IDLE, the arbiter SHALL select exactly one asserted valid and assert only that requester's ready, combinationally, in the same cycle.
REQ-016 A handshake (valid && ready) SHALL register the operands, opcode and id, clear the cycle counter and move to EXEC.
REQ-017 In IDLE with no valid asserted, the FSM SHALL remain in IDLE with both readys low.
REQ-018 In EXEC, alu_a, alu_b and alu_op SHALL come from the registered values; outside EXEC they SHALL be 0, 0 and 38 (ERROR).
REQ-019 In EXEC, the counter SHALL increment each cycle; at count EXEC_CYCLES-1 the block SHALL register alu_result, alu_negative and alu_zero and move to RESP.
REQ-020 In RESP, rsp_valid SHALL be high and the rsp_* outputs SHALL stay stable until rsp_ready is sampled high; the FSM then returns to IDLE.
REQ-021 Latency: for a handshake in cycle T, rsp_valid SHALL rise in cycle T+1+EXEC_CYCLES; the next grant is possible no earlier than the cycle after response acceptance.
REQ-022 Both readys SHALL be low in EXEC and RESP; requester valids SHALL be ignored in those states.
REQ-023 Opcodes SHALL pass through unmodified, including unsupported codes; the ALU result for those is returned as-is.
REQ-024 The round-robin pointer SHALL favour the requester not granted most recently; when both are valid, the favoured one wins.
REQ-025 A valid that drops before grant SHALL be discarded without a capture.
REQ-026 Back-pressure: rsp_ready held low SHALL keep the FSM in RESP indefinitely, with no new grant.

Reset
REQ-027 While nRst is low at a clock edge, the block SHALL set:
- state IDLE and pointer to requester 0;
- counter, rsp_valid, rsp_id, rsp_result, rsp_negative, rsp_zero and busy to 0;
- all operand and opcode registers to 0, except the opcode register, which is set to 38.
REQ-028 Reset asserted in EXEC or RESP SHALL abort the operation; no response is issued for the aborted operation.

Configuration
REQ-029 With ALU_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win when both are valid and the pointer logic SHALL be absent.
REQ-030 Without ALU_ARB_FIXED_PRIO_EN, arbitration SHALL follow REQ-024.

Verification
REQ-031 EXEC_CYCLES=1, req0 ADD a=5 b=7, rsp_ready=1 -> handshake at T; rsp_valid at T+2 with rsp_id=0, rsp_result=12, zero=0, negative=0.
REQ-032 req1 SUB a=3 b=3 -> rsp_result=0, rsp_zero=1; then SUB a=2 b=5 -> rsp_result=0xFFFFFFFD, rsp_negative=1.
REQ-033 Both valid continuously, four ops, round-robin build -> grants 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-034 EXEC_CYCLES=3, req0 AND a=0xF0 b=0x3C, rsp_ready low for 5 cycles -> rsp_valid at T+4, result 0x30 held stable, both readys low until acceptance.
REQ-035 nRst low for one edge during EXEC -> next cycle state IDLE, busy=0, rsp_valid=0, alu_op=38; a later req1 request is granted first-come.
REQ-036 req0 op=50 a=1 b=1 -> handshake accepted; response rsp_result=0, rsp_zero=0.
